regfile_sb: RTL and testbench

- 32x32 MIPS general-purpose register file, one write port and two read ports, plus HI/LO registers.
- Includes a per-register load-pending scoreboard.
- Sits in the ID/WB boundary: ID reads operands and checks hazards here; WB writes results back.
- The write address is converted to a one-hot row select by the existing 5-to-32 one-hot decoder. That select gates each register's write enable and scoreboard clear.

---
 rtl/regfile_sb_pkg.sv | 24 ++
 rtl/regfile_sb_dec.sv | 23 ++
 rtl/regfile_sb.sv | 171 +++++++++++++++++
 tb/tb_regfile_sb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Shared constants and types for the register file / load scoreboard slice.
//   REG_NUM   : number of general-purpose registers.
//   ZERO_REG  : architectural zero register index (hard-wired to 0).
//   WB_BUS_W  : width of the WB write-back bus {we, waddr, wdata}, so the
//               ID and WB stage buses agree on one layout.
//   wb_bus_t  : packed view of that bus, field order matching WB_BUS_W.
package regfile_sb_pkg;

  localparam int         REG_NUM   = 32;
  localparam logic [4:0] ZERO_REG  = 5'd0;

  localparam int WB_WE_W   = 1;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_BUS_W  = WB_WE_W + WB_ADDR_W + WB_DATA_W;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_bus_t;

endpackage

// File: rtl/regfile_sb_dec.sv
// regfile_sb_dec
// One-hot row decoder: sel[i] = en && (addr == i).
// Ports:
//   en   in  1       : qualifies the whole decode (all-zero when low).
//   addr in  AW      : row address.
//   sel  out 2**AW   : one-hot (or all-zero) row select.
module regfile_sb_dec #(
  parameter int AW = 5
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  sel
);

  // Compare the address against every row index, gated by the enable.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 2**AW; i++) begin
      sel[i] = en && (addr == AW'(i));
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// 32x32 MIPS GPR file (1W/2R, write-through bypass), HI/LO registers and a
// per-register load-pending scoreboard that drives the ID-stage stall.
// Ports:
//   clk, resetn                : rising-edge clock, async active-low reset.
//   raddr1/rdata1, raddr2/rdata2 : combinational read ports (rs / rt).
//   we, waddr, wdata           : WB-stage GPR write port.
//   hi_we/hi_wdata/hi_rdata    : HI register write/read.
//   lo_we/lo_wdata/lo_rdata    : LO register write/read.
//   ld_issue, ld_dst           : load issued from ID and its destination.
//   busy                       : scoreboard vector, bit i = load pending on ri.
//   stall                      : ID must stall on a busy, non-bypassed operand.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AW-1:0]     raddr1,
  output logic [DW-1:0]     rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DW-1:0]     rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DW-1:0]     hi_wdata,
  input  logic [DW-1:0]     lo_wdata,
  output logic [DW-1:0]     hi_rdata,
  output logic [DW-1:0]     lo_rdata,
  input  logic              ld_issue,
  input  logic [AW-1:0]     ld_dst,
  output logic [2**AW-1:0]  busy,
  output logic              stall
);

  localparam int NREG = 2**AW;
  // Bit 0 of the scoreboard can never be set: r0 has no producer.
  localparam logic [NREG-1:0] SB_SET_MASK = ~{{(NREG-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   ZERO_ADDR   = AW'(ZERO_REG);

  wb_bus_t wb_s;
  assign wb_s = {we, waddr, wdata};

  logic [NREG-1:0] wsel_s;
  logic [NREG-1:0] lsel_s;

  // Write/clear row select: one-hot waddr qualified by we.
  regfile_sb_dec #(.AW(AW)) u_wdec (
    .en   (wb_s.we),
    .addr (wb_s.waddr),
    .sel  (wsel_s)
  );

  // Scoreboard set row select: one-hot ld_dst qualified by ld_issue.
  regfile_sb_dec #(.AW(AW)) u_ldec (
    .en   (ld_issue),
    .addr (ld_dst),
    .sel  (lsel_s)
  );

  logic [DW-1:0]   gpr_q [NREG];
  logic [DW-1:0]   gpr_d [NREG];
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Next-state for GPRs, HI/LO and the scoreboard.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (wsel_s[i]) begin
        gpr_d[i] = wb_s.wdata;
      end else begin
        gpr_d[i] = gpr_q[i];
      end
    end
    // r0 is hard-wired; the row select may hit it but the write is dropped.
    gpr_d[0] = '0;

    if (hi_we) begin
      hi_d = hi_wdata;
    end else begin
      hi_d = hi_q;
    end

    if (lo_we) begin
      lo_d = lo_wdata;
    end else begin
      lo_d = lo_q;
    end

    // Clear first, then set: a new load to the retiring register stays pending.
    busy_d = (busy_q & ~wsel_s) | (lsel_s & SB_SET_MASK);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

  // Read ports with WB bypass; forced to 0 while reset is asserted, since
  // a bypassed wdata would otherwise leak through during reset.
  always_comb begin
    if (!resetn) begin
      rdata1   = '0;
      rdata2   = '0;
      hi_rdata = '0;
      lo_rdata = '0;
    end else begin
      if (raddr1 == ZERO_ADDR) begin
        rdata1 = '0;
      end else if (wsel_s[raddr1]) begin
        rdata1 = wb_s.wdata;
      end else begin
        rdata1 = gpr_q[raddr1];
      end

      if (raddr2 == ZERO_ADDR) begin
        rdata2 = '0;
      end else if (wsel_s[raddr2]) begin
        rdata2 = wb_s.wdata;
      end else begin
        rdata2 = gpr_q[raddr2];
      end

      if (hi_we) begin
        hi_rdata = hi_wdata;
      end else begin
        hi_rdata = hi_q;
      end

      if (lo_we) begin
        lo_rdata = lo_wdata;
      end else begin
        lo_rdata = lo_q;
      end
    end
  end

  // Hazard detect: wsel_s[raddrN] is exactly (we && waddr == raddrN), so a
  // busy operand being written back this cycle is covered by the bypass.
  // busy_q[0] is always 0, so raddr 0 never stalls.
  always_comb begin
    if (!resetn) begin
      stall = 1'b0;
    end else begin
      stall = (busy_q[raddr1] && !wsel_s[raddr1]) ||
              (busy_q[raddr2] && !wsel_s[raddr2]);
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Self-checking bench for regfile_sb: a directed vector table, a mid-cycle
// reset sequence and randomized traffic compared against an array-based
// reference model of the register file, HI/LO and scoreboard.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  raddr1, raddr2, waddr, ld_dst;
  logic [31:0] rdata1, rdata2, wdata;
  logic        we, hi_we, lo_we, ld_issue;
  logic [31:0] hi_wdata, lo_wdata, hi_rdata, lo_rdata;
  logic [31:0] busy;
  logic        stall;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk      (clk),
    .resetn   (resetn),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata),
    .ld_issue (ld_issue),
    .ld_dst   (ld_dst),
    .busy     (busy),
    .stall    (stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [32];
  logic [31:0] m_hi, m_lo;
  bit          m_busy [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  // Apply what the clock edge does with the inputs currently driven.
  task automatic model_commit();
    if (we && waddr != 5'd0) m_reg[waddr] = wdata;
    if (we) m_busy[waddr] = 1'b0;
    if (ld_issue && ld_dst != 5'd0) m_busy[ld_dst] = 1'b1;
    if (hi_we) m_hi = hi_wdata;
    if (lo_we) m_lo = lo_wdata;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_hazard(input logic [4:0] a);
    return (a != 5'd0) && m_busy[a] && !(we && waddr == a);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".rdata1"}, rdata1, exp_rd(raddr1));
    chk({tag, ".rdata2"}, rdata2, exp_rd(raddr2));
    chk({tag, ".stall"}, 32'(stall), 32'(exp_hazard(raddr1) || exp_hazard(raddr2)));
    chk({tag, ".busy"}, busy, exp_busy());
    chk({tag, ".hi"}, hi_rdata, hi_we ? hi_wdata : m_hi);
    chk({tag, ".lo"}, lo_rdata, lo_we ? lo_wdata : m_lo);
  endtask

  task automatic set_idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = 32'h0; lo_wdata = 32'h0;
    ld_issue = 1'b0; ld_dst = 5'd0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1, ra2;
    logic        ld;
    logic [4:0]  ldd;
    logic        hwe, lwe;
    logic [31:0] hwd, lwd;
    logic [31:0] e_r1, e_r2;
    logic        e_st;
    logic [31:0] e_busy, e_hi, e_lo;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  initial begin
    // we waddr wdata ra1 ra2 ld ldd hwe lwe hwd lwd | r1 r2 stall busy hi lo
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b1, 32'h100, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 5'd8, 32'h55, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h55, 1'b0, 32'h100, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h55, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 5'd9, 32'h77, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h77, 32'h0, 1'b0, 32'h200, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h77, 32'h0, 1'b1, 32'h200, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h1, 32'h2,
                32'h0, 32'h0, 1'b0, 32'h200, 32'h1, 32'h2};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hAAAA, 32'h3,
                32'h0, 32'h0, 1'b0, 32'h200, 32'h1, 32'h3};
    tbl[13] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h200, 32'h1, 32'h3};
    tbl[14] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h200, 32'h1, 32'h3};
    tbl[15] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h200, 32'h1, 32'h3};
    tbl[16] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'hDEADBEEF, 32'h77, 1'b1, 32'h200, 32'h1, 32'h3};
  end

  initial begin
    string tag;
    logic  full;

    // Reset state.
    resetn = 1'b0;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    raddr1 = 5'd3;
    raddr2 = 5'd7;
    #3;
    chk("rst.rdata1", rdata1, 32'h0);
    chk("rst.rdata2", rdata2, 32'h0);
    chk("rst.busy", busy, 32'h0);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.hi", hi_rdata, 32'h0);
    chk("rst.lo", lo_rdata, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    set_idle();

    // Directed table, one row per clock.
    for (int v = 0; v < NVEC; v++) begin
      we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
      raddr1 = tbl[v].ra1; raddr2 = tbl[v].ra2;
      ld_issue = tbl[v].ld; ld_dst = tbl[v].ldd;
      hi_we = tbl[v].hwe; lo_we = tbl[v].lwe;
      hi_wdata = tbl[v].hwd; lo_wdata = tbl[v].lwd;
      #4;
      tag = $sformatf("vec%0d", v);
      chk({tag, ".rdata1"}, rdata1, tbl[v].e_r1);
      chk({tag, ".rdata2"}, rdata2, tbl[v].e_r2);
      chk({tag, ".stall"}, 32'(stall), 32'(tbl[v].e_st));
      chk({tag, ".busy"}, busy, tbl[v].e_busy);
      chk({tag, ".hi"}, hi_rdata, tbl[v].e_hi);
      chk({tag, ".lo"}, lo_rdata, tbl[v].e_lo);
      @(posedge clk);
      model_commit();
      #1;
    end

    // Mid-cycle reset: reg3 holds 0x1234, busy[9] is set, a write is on the bus.
    set_idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'h1234;
    @(posedge clk);
    model_commit();
    #1;
    set_idle();
    raddr1 = 5'd3;
    raddr2 = 5'd9;
    #2;
    chk("prerst.rdata1", rdata1, 32'h1234);
    chk("prerst.stall", 32'(stall), 32'h1);
    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF;
    resetn = 1'b0;
    #1;
    chk("midrst.rdata1", rdata1, 32'h0);
    chk("midrst.rdata2", rdata2, 32'h0);
    chk("midrst.busy", busy, 32'h0);
    chk("midrst.stall", 32'(stall), 32'h0);
    chk("midrst.hi", hi_rdata, 32'h0);
    chk("midrst.lo", lo_rdata, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    set_idle();
    raddr1 = 5'd3;
    raddr2 = 5'd9;
    #4;
    check_model("postrst");
    chk("postrst.r3", rdata1, 32'h0);
    @(posedge clk);
    model_commit();
    #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      full = ($urandom_range(0, 3) == 0);
      we       = $urandom_range(0, 1);
      waddr    = full ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wdata    = $urandom;
      raddr1   = full ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      raddr2   = 5'($urandom_range(0, 7));
      ld_issue = ($urandom_range(0, 2) == 0);
      ld_dst   = full ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      hi_we    = ($urandom_range(0, 3) == 0);
      lo_we    = ($urandom_range(0, 3) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      #4;
      check_model($sformatf("rnd%0d", c));
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
